// File: rtl/i2s_tx_pkg.sv
// Shared I2S definitions: frame geometry, LRCLK channel encoding and parameter range checks.
// Reused by the transmitter and by the future receiver / loopback checker.
package i2s_tx_pkg;

    localparam int SAMPLE_W_MIN = 8;
    localparam int SAMPLE_W_MAX = 32;
    localparam int BCLK_DIV_MIN = 1;

    // Word-select level on the wire: low selects the left channel.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    function automatic int frame_len(input int sample_w);
        return 2 * sample_w;
    endfunction

    // Counter width that stays at least one bit for a modulus of 1.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    function automatic bit sample_w_ok(input int sample_w);
        return (sample_w >= SAMPLE_W_MIN) && (sample_w <= SAMPLE_W_MAX);
    endfunction

    function automatic bit bclk_div_ok(input int bclk_div);
        return bclk_div >= BCLK_DIV_MIN;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides the fabric clock down to BCLK and counts bit slots in a frame,
// producing the falling-event and frame-start strobes that pace the serializer.
module i2s_bclk_gen
    import i2s_tx_pkg::*;
#(
    parameter  int SAMPLE_W  = 16,
    parameter  int BCLK_DIV  = 4,
    localparam int FRAME_LEN = frame_len(SAMPLE_W),
    localparam int BIT_W     = cnt_width(FRAME_LEN)
) (
    input  logic             clock_in,
    input  logic             reset,
    output logic             bclk,
    output logic             fall_event,
    output logic             frame_start,
    output logic [BIT_W-1:0] bit_cnt_next
);

    localparam int               DIV_W    = cnt_width(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             div_tc;

    assign div_tc       = (div_cnt == DIV_LAST);
    // A terminal count while BCLK is high means this edge drives BCLK low.
    assign fall_event   = div_tc && bclk;
    assign frame_start  = fall_event && (bit_cnt == BIT_LAST);
    assign bit_cnt_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= BIT_LAST;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_event) begin
                bit_cnt <= bit_cnt_next;
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: accepts stereo pairs on a valid/ready handshake into a one-entry
// buffer and serializes them MSB-first, delayed one BCLK behind each LRCLK edge.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_left,
    input  logic [SAMPLE_W-1:0] sample_right,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underrun
);

    localparam int FRAME_LEN = frame_len(SAMPLE_W);
    localparam int BIT_W     = cnt_width(FRAME_LEN);

    if (!sample_w_ok(SAMPLE_W)) begin : g_bad_sample_w
        $error("i2s_tx: SAMPLE_W must be within 8..32");
    end
    if (!bclk_div_ok(BCLK_DIV)) begin : g_bad_bclk_div
        $error("i2s_tx: BCLK_DIV must be at least 1");
    end

    logic                 fall_event;
    logic                 frame_start;
    logic [BIT_W-1:0]     bit_cnt_next;

    logic [FRAME_LEN-1:0] shreg;
    logic [SAMPLE_W-1:0]  pend_left;
    logic [SAMPLE_W-1:0]  pend_right;
    logic                 pending_full;
    logic                 sdata_q;
    logic                 underrun_q;
    channel_e             lr_q;
    logic                 accept;

    i2s_bclk_gen #(
        .SAMPLE_W (SAMPLE_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clock_in     (clock_in),
        .reset        (reset),
        .bclk         (i2s_bclk),
        .fall_event   (fall_event),
        .frame_start  (frame_start),
        .bit_cnt_next (bit_cnt_next)
    );

    assign accept = sample_valid && !pending_full;

    // The frame start reads the buffer as it was before this edge; a pair accepted on the
    // same edge waits for the next frame.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            shreg        <= '0;
            sdata_q      <= 1'b0;
            lr_q         <= CH_RIGHT;
            underrun_q   <= 1'b0;
            pending_full <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (fall_event) begin
                sdata_q <= shreg[FRAME_LEN-1];
                lr_q    <= (bit_cnt_next >= BIT_W'(SAMPLE_W)) ? CH_RIGHT : CH_LEFT;
                if (frame_start) begin
                    if (pending_full) begin
                        shreg <= {pend_left, pend_right};
                    end else begin
                        shreg      <= '0;
                        underrun_q <= 1'b1;
                    end
                end else begin
                    shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
                end
            end
            if (accept) begin
                pending_full <= 1'b1;
            end else if (frame_start) begin
                pending_full <= 1'b0;
            end
        end
    end

    // NOTE: the buffer payload has no reset; pending_full gates every use of it.
    always_ff @(posedge clock_in) begin
        if (accept) begin
            pend_left  <= sample_left;
            pend_right <= sample_right;
        end
    end

    assign sample_ready = !pending_full;
    assign i2s_lrclk    = lr_q;
    assign i2s_sdata    = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: reset behaviour, single frame, underrun, same-edge handshake,
// back-to-back streaming at default parameters, and a SAMPLE_W=24 / BCLK_DIV=1 instance.
module tb_i2s_tx;

    localparam int SW0  = 16;
    localparam int DIV0 = 4;
    localparam int SW1  = 24;
    localparam int DIV1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst0, v0, rdy0, bclk0, lrclk0, sdata0, ur0;
    logic [SW0-1:0] l0, r0;
    logic           rst1, v1, rdy1, bclk1, lrclk1, sdata1, ur1;
    logic [SW1-1:0] l1, r1;

    i2s_tx #(.SAMPLE_W(SW0), .BCLK_DIV(DIV0)) dut0 (
        .clock_in     (clk),
        .reset        (rst0),
        .sample_left  (l0),
        .sample_right (r0),
        .sample_valid (v0),
        .sample_ready (rdy0),
        .i2s_bclk     (bclk0),
        .i2s_lrclk    (lrclk0),
        .i2s_sdata    (sdata0),
        .underrun     (ur0)
    );

    i2s_tx #(.SAMPLE_W(SW1), .BCLK_DIV(DIV1)) dut1 (
        .clock_in     (clk),
        .reset        (rst1),
        .sample_left  (l1),
        .sample_right (r1),
        .sample_valid (v1),
        .sample_ready (rdy1),
        .i2s_bclk     (bclk1),
        .i2s_lrclk    (lrclk1),
        .i2s_sdata    (sdata1),
        .underrun     (ur1)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ur_cnt0 = 0;
    logic fell0 = 1'b0, fell1 = 1'b0;
    logic bclk0_q, bclk1_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        bclk0_q = bclk0;
        bclk1_q = bclk1;
        @(posedge clk);
        #1;
        cyc++;
        fell0 = bclk0_q && !bclk0;
        fell1 = bclk1_q && !bclk1;
        if (ur0) ur_cnt0++;
    endtask

    task automatic wait_fall(input int which);
        for (int i = 0; i < 64; i++) begin
            tick();
            if ((which == 0) ? fell0 : fell1) return;
        end
        n_cmp++;
        n_fail++;
        $error("FAIL fall_timeout: dut%0d observed no BCLK fall, required one within 64 cycles", which);
    endtask

    // Records one frame of slots, starting at the current frame start (slot 0).
    task automatic capture(input int which, output logic [63:0] sd, output logic [63:0] lr);
        int n;
        n  = (which == 0) ? 2 * SW0 : 2 * SW1;
        sd = '0;
        lr = '0;
        sd[0] = (which == 0) ? sdata0 : sdata1;
        lr[0] = (which == 0) ? lrclk0 : lrclk1;
        for (int i = 1; i < n; i++) begin
            wait_fall(which);
            sd[i] = (which == 0) ? sdata0 : sdata1;
            lr[i] = (which == 0) ? lrclk0 : lrclk1;
        end
    endtask

    // I2S wire model: slot 0 holds the previous word's LSB, slot k holds word bit n-k.
    function automatic logic [63:0] exp_sdata(input int n, input logic [63:0] word, input logic prev_lsb);
        logic [63:0] e;
        e    = '0;
        e[0] = prev_lsb;
        for (int k = 1; k < n; k++) e[k] = word[n-k];
        return e;
    endfunction

    function automatic logic [63:0] exp_lr(input int n);
        logic [63:0] e;
        e = '0;
        for (int k = 0; k < n; k++) e[k] = (k >= n / 2);
        return e;
    endfunction

    logic [63:0] sd, lr;
    logic [31:0] tx_q [64];
    logic [31:0] rx   [64];
    logic [47:0] wa, wb;
    logic        acc, prev_rdy;
    int          fs_a, fs_b, ur_base, ur_mid, idx, fall_idx, rises, bad, last_rise, errs, t0;
    bit          found;

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        v0 = 1'b0; l0 = '0; r0 = '0;
        v1 = 1'b0; l1 = '0; r1 = '0;
        repeat (3) tick();
        check("rst_bclk",     64'(bclk0),  64'd0);
        check("rst_lrclk",    64'(lrclk0), 64'd1);
        check("rst_sdata",    64'(sdata0), 64'd0);
        check("rst_ready",    64'(rdy0),   64'd1);
        check("rst_underrun", 64'(ur0),    64'd0);

        // Release just after an edge; the following edges are numbered 1, 2, ...
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (3) tick();
        check("bclk_low_edge3", 64'(bclk0), 64'd0);
        tick();
        check("bclk_rise_edge4", 64'(bclk0), 64'd1);
        repeat (3) tick();
        check("lrclk_before_fs", 64'(lrclk0), 64'd1);
        tick();
        fs_a = cyc;
        check("bclk_fall_edge8", 64'(bclk0), 64'd0);
        check("lrclk_fs_edge8",  64'(lrclk0), 64'd0);
        check("underrun_first",  64'(ur0),   64'd1);
        ur_base = ur_cnt0;

        // Single frame: pair accepted during the underrun frame, sent in the next one.
        l0 = 16'hA5C3; r0 = 16'h0F0F; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        check("underrun_one_cycle", 64'(ur0),  64'd0);
        check("ready_low_accept",   64'(rdy0), 64'd0);
        capture(0, sd, lr);
        check("first_frame_zero",   sd, 64'd0);
        check("first_frame_lrclk",  lr, exp_lr(2 * SW0));
        check("first_frame_pulses", 64'(ur_cnt0 - ur_base), 64'd0);
        wait_fall(0);
        check("frame_period",  64'(cyc - fs_a), 64'd256);
        fs_a = cyc;
        check("loaded_no_ur",  64'(ur0),  64'd0);
        check("ready_fs",      64'(rdy0), 64'd1);
        capture(0, sd, lr);
        check("single_sdata",  sd, exp_sdata(2 * SW0, 64'h0000_0000_A5C3_0F0F, 1'b0));
        check("single_lrclk",  lr, exp_lr(2 * SW0));

        // Underrun frame after the single pair.
        wait_fall(0);
        fs_a = cyc;
        check("slot0_right_lsb", 64'(sdata0), 64'd1);
        check("underrun_pulse",  64'(ur0),    64'd1);
        ur_base = ur_cnt0;
        capture(0, sd, lr);
        check("underrun_sdata",  sd, 64'd1);
        check("underrun_single", 64'(ur_cnt0 - ur_base), 64'd0);

        // Handshake on exactly the frame-start edge with the buffer empty.
        while (cyc < fs_a + 255) tick();
        l0 = 16'h8001; r0 = 16'h7FFE; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        fs_a = cyc;
        check("sim_fall_edge", 64'(fell0), 64'd1);
        check("sim_underrun",  64'(ur0),   64'd1);
        check("sim_accepted",  64'(rdy0),  64'd0);
        capture(0, sd, lr);
        check("sim_frame_zero", sd, 64'd0);
        check("sim_ready_held", 64'(rdy0), 64'd0);
        wait_fall(0);
        check("sim_next_period", 64'(cyc - fs_a), 64'd256);
        check("sim_ready_fs",    64'(rdy0), 64'd1);
        check("sim_no_underrun", 64'(ur0),  64'd0);
        capture(0, sd, lr);
        check("sim_sdata", sd, exp_sdata(2 * SW0, 64'h0000_0000_8001_7FFE, 1'b0));
        wait_fall(0);

        // Back-to-back streaming from this frame start (an underrun frame, buffer empty).
        for (int i = 0; i < 64; i++) begin
            tx_q[i] = $urandom();
            rx[i]   = '0;
        end
        idx = 0; fall_idx = 0; rises = 0; bad = 0; last_rise = 0;
        ur_base = ur_cnt0; ur_mid = -1; t0 = cyc;
        {l0, r0} = tx_q[0];
        v0 = 1'b1;
        while (fall_idx < 2080 && cyc < t0 + 17000) begin
            acc      = v0 && rdy0;
            prev_rdy = rdy0;
            tick();
            if (acc) begin
                idx++;
                if (idx < 64) {l0, r0} = tx_q[idx];
                else v0 = 1'b0;
            end
            if (!prev_rdy && rdy0) begin
                rises++;
                if (rises > 1 && cyc - last_rise != 256) bad++;
                last_rise = cyc;
            end
            if (fell0) begin
                fall_idx++;
                // Pair i occupies slots 1..32 of frame i+1, i.e. falls 33+32i .. 64+32i.
                if (fall_idx >= 33 && fall_idx < 33 + 2048)
                    rx[(fall_idx - 33) / 32][31 - ((fall_idx - 33) % 32)] = sdata0;
                if (fall_idx == 2079) ur_mid = ur_cnt0;
            end
        end
        errs = 0;
        for (int i = 0; i < 64; i++) if (rx[i] !== tx_q[i]) errs++;
        check("stream_complete",  64'(fall_idx), 64'd2080);
        check("stream_first",     64'(rx[0]),  64'(tx_q[0]));
        check("stream_last",      64'(rx[63]), 64'(tx_q[63]));
        check("stream_bad_pairs", 64'(errs), 64'd0);
        check("stream_underruns", 64'(ur_mid - ur_base), 64'd0);
        check("stream_rises",     64'(rises), 64'd64);
        check("stream_rise_gap",  64'(bad), 64'd0);
        check("stream_tail_ur",   64'(ur0), 64'd1);

        // Asynchronous reset mid-frame with a pair pending.
        l0 = 16'hFFFF; r0 = 16'hFFFF; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        repeat (100) tick();
        check("pre_rst_ready", 64'(rdy0),   64'd0);
        check("pre_rst_lrclk", 64'(lrclk0), 64'd0);
        check("pre_rst_bclk",  64'(bclk0),  64'd1);
        #3 rst0 = 1'b1;
        #1;
        check("async_bclk",     64'(bclk0),  64'd0);
        check("async_lrclk",    64'(lrclk0), 64'd1);
        check("async_sdata",    64'(sdata0), 64'd0);
        check("async_ready",    64'(rdy0),   64'd1);
        check("async_underrun", 64'(ur0),    64'd0);
        rst0 = 1'b0;
        repeat (7) tick();
        check("rerun_bclk_high", 64'(bclk0),  64'd1);
        check("rerun_lrclk",     64'(lrclk0), 64'd1);
        tick();
        check("rerun_fall_edge8",  64'(fell0), 64'd1);
        check("rerun_discard_ur",  64'(ur0),   64'd1);

        // SAMPLE_W=24, BCLK_DIV=1 instance: align to one of its (underrun) frame starts.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (ur1) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sweep_align: observed no underrun pulse, required one within 200 cycles");
        end
        wa = {24'hC3A55A, 24'h00FF01};
        wb = {24'h123456, 24'hFEDCBA};
        fs_b = cyc;
        {l1, r1} = wa; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        check("sweep_accept",   64'(rdy1),  64'd0);
        check("sweep_bclk_hi",  64'(bclk1), 64'd1);
        wait_fall(1);
        check("sweep_bclk_period", 64'(cyc - fs_b), 64'd2);
        for (int i = 2; i < 2 * SW1; i++) wait_fall(1);
        wait_fall(1);
        check("sweep_frame_period", 64'(cyc - fs_b), 64'd96);
        check("sweep_loaded",       64'(ur1), 64'd0);
        fs_b = cyc;
        capture(1, sd, lr);
        check("sweep_slot47_time", 64'(cyc - fs_b), 64'd94);
        check("sweep_a_sdata", sd, exp_sdata(2 * SW1, 64'(wa), 1'b0));
        check("sweep_a_lrclk", lr, exp_lr(2 * SW1));
        wait_fall(1);
        check("sweep_a_lsb",  64'(sdata1), 64'd1);
        check("sweep_ur",     64'(ur1),    64'd1);
        {l1, r1} = wb; v1 = 1'b1;
        capture(1, sd, lr);
        v1 = 1'b0;
        check("sweep_ur_frame", sd, 64'd1);
        wait_fall(1);
        capture(1, sd, lr);
        check("sweep_b_sdata", sd, exp_sdata(2 * SW1, 64'(wb), 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
